// File: rtl/muldiv_sequencer.sv
// Iterative 32-step multiply / restoring-divide sequencer for MULT/MULTU/DIV/DIVU with HI/LO results.
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves RUN once the unconsumed multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] upper_q, upper_d;   // multiply accumulator / divide remainder
  logic [WIDTH-1:0] lower_q, lower_d;   // multiplier / dividend-then-quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand / divisor
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_quot_q, sign_quot_d;
  logic             sign_rem_q, sign_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  logic             is_div, is_signed, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_upper, mul_lower;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_upper, div_lower;
  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  assign a_mag = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Shift-add step: the carry out of the 33-bit sum becomes the new accumulator MSB.
  assign mul_sum   = lower_q[0] ? ({1'b0, upper_q} + {1'b0, opnd_q}) : {1'b0, upper_q};
  assign mul_upper = mul_sum[WIDTH:1];
  assign mul_lower = {mul_sum[0], lower_q[WIDTH-1:1]};

  // Restoring step: the remainder stays below the divisor, so the shifted value needs one extra bit.
  assign rem_sh    = {upper_q, lower_q[WIDTH-1]};
  assign div_diff  = {1'b0, rem_sh} - {2'b00, opnd_q};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign div_upper = div_ok ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_lower = {lower_q[WIDTH-2:0], div_ok};

  assign product  = {upper_q, lower_q};
  assign prod_fix = (is_signed && sign_quot_q) ? -product : product;
  assign quot_fix = (is_signed && sign_quot_q) ? -lower_q : lower_q;
  assign rem_fix  = (is_signed && sign_rem_q)  ? -upper_q : upper_q;

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0]   done_iters;
  logic [WIDTH-1:0]   live_mask;
  logic               early_exit;
  logic [2*WIDTH-1:0] early_prod;

  // After k steps only the low WIDTH-k multiplier bits are still unconsumed.
  assign done_iters = cnt_q + 1'b1;
  assign live_mask  = {WIDTH{1'b1}} >> done_iters;
  assign early_exit = ~is_div && ((mul_lower & live_mask) == '0);
  assign early_prod = {mul_upper, mul_lower} >> (CNT_W'(WIDTH) - done_iters);
`endif

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    upper_d     = upper_q;
    lower_d     = lower_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    sign_quot_d = sign_quot_q;
    sign_rem_d  = sign_rem_q;
    dbz_d       = dbz_q;
    hi_d        = hi;
    lo_d        = lo;

    busy        = (state_q != S_IDLE);
    stall       = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
    done        = (state_q == S_DONE);
    div_by_zero = (state_q == S_DONE) && dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_PREP;
          op_d    = op;
          a_d     = data_a;
          b_d     = data_b;
        end
      end

      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (is_div && (b_q == '0)) begin
          state_d = S_DONE;
          hi_d    = a_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
        end else begin
          state_d     = S_RUN;
          cnt_d       = '0;
          upper_d     = '0;
          lower_d     = is_div ? a_mag : b_mag;
          opnd_d      = is_div ? b_mag : a_mag;
          sign_quot_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          sign_rem_d  = is_signed & a_q[WIDTH-1];
        end
      end

      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div) begin
            upper_d = div_upper;
            lower_d = div_lower;
          end else begin
            upper_d = mul_upper;
            lower_d = mul_lower;
          end
          if (last_iter) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_exit) begin
            {upper_d, lower_d} = early_prod;
            state_d            = S_FIX;
          end
`endif
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          dbz_d   = 1'b0;
          if (is_div) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      upper_q     <= '0;
      lower_q     <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      sign_quot_q <= 1'b0;
      sign_rem_q  <= 1'b0;
      dbz_q       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      upper_q     <= upper_d;
      lower_q     <= lower_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      sign_quot_q <= sign_quot_d;
      sign_rem_q  <= sign_rem_d;
      dbz_q       <= dbz_d;
      hi          <= hi_d;
      lo          <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: transaction-level timing/result model plus directed literal checks.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        flush;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .data_a(data_a), .data_b(data_b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dbz;
    int          lat;
  } res_t;

  // Result from plain arithmetic; latency = edge (counting the start edge as 1) after which done is high.
  function automatic res_t predict(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    longint      sa, sb, q, rm;
    logic [63:0] p;
    logic [31:0] mb;
    int          k;
    sa = $signed(a);
    sb = $signed(b);
    r.dbz = 0;
    r.lat = 35;
    p = '0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) begin
          r.dbz = 1;
          r.lat = 2;
          p = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q = sa / sb;
          rm = sa % sb;
          p = {rm[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      mb = (o == 2'b00 && b[31]) ? -b : b;
      k = 1;
      while (k < 32 && (mb >> k) != 0) k++;
      r.lat = k + 3;
    end
`endif
    r.hi = p[63:32];
    r.lo = p[31:0];
    return r;
  endfunction

  // Model: m_t counts edges since the accepted start; done is expected when m_t equals the latency.
  int          m_t = 0;
  res_t        m_res;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_t  <= 0;
      m_hi <= '0;
      m_lo <= '0;
    end else if (m_t == 0) begin
      if (start && !flush) begin
        m_res <= predict(op, data_a, data_b);
        m_t   <= 1;
      end
    end else if (flush || m_t == m_res.lat) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 == m_res.lat) begin
        m_hi <= m_res.hi;
        m_lo <= m_res.lo;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      check("busy",  busy,  m_t != 0);
      check("stall", stall, m_t != 0 && m_t < m_res.lat);
      check("done",  done,  m_t != 0 && m_t == m_res.lat);
      check("dbz",   div_by_zero, m_t != 0 && m_t == m_res.lat && m_res.dbz);
      check("hi",    hi, m_hi);
      check("lo",    lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1;
    start  = 1'b1;
    flush  = 1'b0;
    op     = o;
    data_a = a;
    data_b = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int stalls, output logic dbz_seen);
    issue(o, a, b);
    edges    = 1;
    stalls   = 0;
    dbz_seen = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (stall) stalls++;
      @(posedge clock);
      #1;
      edges++;
    end
    if (!done) check("done_timeout", done, 1);
    else dbz_seen = div_by_zero;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  int   edges, stalls, done_cnt;
  logic dbz_seen;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'b00;
    data_a = '0;
    data_b = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    cmp_en = 1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, stalls, dbz_seen);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_lat", edges, 35);
    check("multu_stall", stalls, 34);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, edges, stalls, dbz_seen);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, edges, stalls, dbz_seen);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, edges, stalls, dbz_seen);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0);

    run_op(2'b11, 32'd100, 32'd0, edges, stalls, dbz_seen);
    check("dbz_lat", edges, 2);
    check("dbz_flag", dbz_seen, 1);
    check("dbz_hi", hi, 32'h0000_0064);
    check("dbz_lo", lo, 32'hFFFF_FFFF);

    run_op(2'b11, 32'd100, 32'd7, edges, stalls, dbz_seen);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);
    check("divu_dbz", dbz_seen, 0);

    // Second DIVU: stray start during RUN, then flush while the counter reads 10.
    issue(2'b11, 32'd200, 32'd3);
    repeat (4) @(posedge clock);
    #1 start = 1'b1; data_a = 32'd9; data_b = 32'd4;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (6) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_hi", hi, 32'd2);
    check("flush_lo", lo, 32'd14);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(posedge clock);
      #1;
    end
    check("flush_no_done", done_cnt, 0);

    run_op(2'b01, 32'd5, 32'd1, edges, stalls, dbz_seen);
    check("early_lo", lo, 32'd5);
    check("early_hi", hi, 32'd0);
`ifdef MULDIV_EARLY_OUT_EN
    check("early_lat", edges, 4);
`else
    check("early_lat", edges, 35);
`endif

    // start coincident with flush in IDLE is dropped.
    @(posedge clock);
    #1 start = 1'b1; flush = 1'b1; op = 2'b01; data_a = 32'd3; data_b = 32'd3;
    @(posedge clock);
    #1 start = 1'b0; flush = 1'b0;
    check("start_flush_busy", busy, 0);

    // Asynchronous reset in the middle of RUN.
    issue(2'b01, 32'h1234, 32'h5678);
    repeat (5) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_stall", stall, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, edges, stalls, dbz_seen);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_hi", hi, 32'd0);

    // Randomized operations with stray starts and occasional flushes while busy.
    for (int n = 0; n < 120; n++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      begin
        bit idle_seen;
        idle_seen = 0;
        for (int c = 0; c < 100; c++) begin
          @(posedge clock);
          #1;
          if (!busy) begin
            idle_seen = 1;
            break;
          end
          start  = ($urandom_range(0, 7) == 0);
          flush  = ($urandom_range(0, 49) == 0);
          op     = 2'($urandom);
          data_a = $urandom;
          data_b = $urandom;
        end
        start = 1'b0;
        flush = 1'b0;
        if (!idle_seen) check("idle_timeout", busy, 0);
      end
    end

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide controller beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU requests and sequences a 32-step shift-add multiply or restoring divide. It also performs sign pre- and post-processing. While an operation runs it stalls the pipeline, and it writes the HI/LO result registers on completion.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request pulse; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
data_a  input  WIDTH  multiplicand / dividend
data_b  input  WIDTH  multiplier / divisor
flush  input  1  synchronous abort from branch/exception logic
busy  output  1  high in any state other than IDLE
stall  output  1  high in PREP, RUN, FIX; holds the pipeline front end
done  output  1  one-cycle pulse; HI/LO valid from this cycle
div_by_zero  output  1  pulse coincident with done for DIV/DIVU with data_b==0
hi  output  WIDTH  product upper half / remainder
lo  output  WIDTH  product lower half / quotient

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; counter, hi, lo, and internal accumulators are 0; busy, stall, done, div_by_zero are 0. Reset mid-operation discards all work.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: on an edge with start=1, latch op, data_a, data_b and go to PREP. start with flush=1 on the same edge is ignored.
- PREP (1 cycle): for signed ops, take magnitudes and record sign_q = a[31]^b[31] and sign_r = a[31]. Unsigned ops use operands unchanged.
  - Divide with b==0: go to DONE with hi=data_a (raw), lo=all ones, div_by_zero=1.
  - Otherwise clear counter and go to RUN.
- RUN: one iteration per cycle; 32 cycles; counter runs 0..31, then go to FIX.
  - Multiply: 64-bit {acc, mplier} shift-add using 33-bit add for the carry.
  - Divide: restoring; shift the remainder left, subtract the divisor, and keep the result if non-negative, shifting in quotient bit 1, else 0.
- FIX (1 cycle):
  - Signed multiply: negate the 64-bit product (two's complement) if sign_q=1.
  - Signed divide: negate the quotient if sign_q=1, and the remainder if sign_r=1.
  - Then go to DONE.
- DONE (1 cycle): hi/lo register written on the entry edge; done=1; next state IDLE. A start in DONE is ignored; the earliest new start is sampled in IDLE.
- Latency (start sampled at edge 1): normal ops have done high after edge 35; divide-by-zero has done high after edge 2.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap is raised.
- start while busy: ignored; no queuing.
- flush=1 in PREP/RUN/FIX/DONE: next state IDLE. hi/lo keep their previous values, or the just-written values if flush occurs in DONE. done is not generated after a flush edge.
- hi/lo change only on entry to DONE or on reset.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: during multiply RUN, if the remaining unshifted multiplier bits are all zero, the block shifts the accumulator by the remaining count in one step and exits to FIX. At least 1 RUN cycle always occurs. Divide timing is unchanged.
- Undefined: fixed 32 RUN cycles for every op. Results are identical either way; only latency differs.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done after edge 35; stall high for 34 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> done and div_by_zero pulse after edge 2; hi=0x00000064, lo=0xFFFFFFFF.
- DIVU a=100 b=7 completes (hi=2, lo=14). Then flush asserted at RUN counter 10 of a second DIVU -> IDLE next cycle; no done; hi=2, lo=14 retained. A start pulse during RUN is ignored.
- reset driven low asynchronously mid-RUN -> busy, stall, hi, lo read 0 immediately. After release, MULTU 6*7 -> lo=42, hi=0.
- With MULDIV_EARLY_OUT_EN defined: MULTU a=5 b=1 -> lo=5, done after edge 4. Without it: same result, done after edge 35.
